aexm_dbus_resp: RTL and testbench
=================================

// Module: aexm_dbus_resp
// PURPOSE
//  Data-side bus responder for the AEXM core. Accepts the precycle word address,
//  byte-lane select and store data from the execute stage. Runs one access
//  against a word-wide memory port that can insert wait states.
//  Returns lane-steered, right-aligned, zero-extended load data and an ack.
//  Raises busy so the pipeline can drop x_en while the access is in flight.
//  Sits between aexm_xecu and the data cache / on-chip RAM.
// PARAMETERS
//  AW   30  word-address width (byte address bits [AW+1:2])
//  TMO  15  max wait cycles for mem_rdy before the access is aborted; 1..255
// PORTS
//  gclk        in   1   clock, all state on rising edge
//  grst_n      in   1   asynchronous, active-low reset
//  pre_addr    in   AW  precycle word address, valid one cycle before dstb
//  dstb        in   1   access request, qualifies dsel/dwe/dwdat
//  dsel        in   4   byte lanes, big-endian: 8=byte0(31:24) .. 1=byte3; C/3 half; F word; 0 FSL
//  dwe         in   1   1=store, 0=load
//  dwdat       in   32  store data, right-aligned
//  drdat       out  32  load data, right-aligned, zero-extended
//  dack        out  1   one-cycle completion pulse
//  derr        out  1   with dack: timeout or illegal dsel
//  dbusy       out  1   access in flight
//  mem_addr    out  AW  memory word address
//  mem_stb     out  1   memory request, held until mem_rdy or abort
//  mem_we      out  1   memory write
//  mem_be      out  4   memory byte enables (= dsel)
//  mem_wdat    out  32  lane-replicated store data
//  mem_rdat    in   32  memory read data, valid with mem_rdy
//  mem_rdy     in   1   memory completes the current access
// BEHAVIOUR
//  Reset values: all outputs 0; FSM in IDLE; address register 0; wait counter 0.
//  Address: pre_addr is registered into addr_q on every IDLE cycle. It is frozen outside IDLE.
//  FSM states: IDLE, MEM, DONE.
//   IDLE -> MEM when dstb & dsel legal & dsel!=0.
//    On that edge: mem_stb=1; mem_addr=addr_q; mem_be=dsel; mem_we=dwe; dbusy=1; counter cleared.
//   IDLE -> DONE when dstb & (dsel==0 | dsel illegal).
//    No memory cycle. derr=1 if illegal, 0 if FSL. drdat=0.
//   MEM -> DONE on mem_rdy. Load data is captured steered; mem_stb drops on the same edge.
//   MEM -> DONE when the counter reaches TMO without mem_rdy. derr=1, drdat=32'hDEAD_DEAD, mem_stb drops.
//   DONE -> IDLE unconditionally. dack=1 for exactly this one cycle; dbusy=0.
//   Best case latency is dstb to dack = 2 cycles, i.e. 1 MEM cycle with mem_rdy.
//  Legal dsel: 0,1,2,4,8,3,C,F. Any other value is illegal.
//  Load steering (dsel -> drdat):
//    8->{24'h0,rd[31:24]}   4->{24'h0,rd[23:16]}   2->{24'h0,rd[15:8]}   1->{24'h0,rd[7:0]}
//    C->{16'h0,rd[31:16]}   3->{16'h0,rd[15:0]}    F->rd
//  Store replication: byte -> {4{dwdat[7:0]}}; half -> {2{dwdat[15:0]}}; word -> dwdat.
//   mem_wdat is registered at the IDLE->MEM edge and held.
//   drdat is 0 on stores.
//  dstb outside IDLE is ignored; the core must not issue while dbusy.
//  mem_rdy outside MEM is ignored.
//  mem_rdy on the same cycle the counter hits TMO: mem_rdy wins, no error.
//  Reset mid-access: the FSM returns to IDLE immediately and mem_stb drops asynchronously.
//   No dack is produced for the aborted access.
//  drdat/derr hold their last value until the next DONE.
// STRUCTURE
//  Shared package aexm_pkg holds:
//   - state encodings (IDLE=2'd0, MEM=2'd1, DONE=2'd2);
//   - DSEL_* lane constants;
//   - the DEAD_DEAD abort pattern.
//  One sub-module, aexm_lane_steer: purely combinational. It takes dsel plus read/write data and produces:
//   - the steered read word;
//   - the replicated write word;
//   - a legal flag.
//  FSM, counter and registers stay in this module.
// TESTING
//  1 Load, pre_addr=0x100, dsel=4, mem_rdat=0x11223344, mem_rdy in 1st MEM cycle
//    -> mem_addr=0x100, dack 2 cycles after dstb, drdat=0x00000022, derr=0.
//  2 Store, dsel=3, dwdat=0xABCD, mem_rdy after 3 waits
//    -> mem_be=3, mem_wdat=0xABCDABCD, mem_we=1, dbusy for 4 cycles, then one dack pulse.
//  3 Load, dsel=F, mem_rdy never asserted, TMO=15
//    -> mem_stb drops after 15 MEM cycles, dack with derr=1, drdat=0xDEADDEAD.
//  4 dsel=0 (FSL), then dsel=5 (illegal)
//    -> no mem_stb in either case; dack derr=0 drdat=0, then dack derr=1.
//  5 grst_n low while in MEM
//    -> mem_stb=0 with no clock edge, no dack follows; the next access completes normally.
//  6 mem_rdy on the same cycle the counter hits TMO
//    -> derr=0, real mem_rdat data is returned.

Source files
------------

// File: rtl/aexm_pkg.sv
// -----------------------------------------------------------------------------
// aexm_pkg
//  Shared definitions for the AEXM data-side bus responder: FSM state
//  encoding, big-endian byte-lane select constants and the pattern returned
//  as load data when a memory access is aborted on timeout.
// -----------------------------------------------------------------------------
package aexm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    DONE = 2'd2
  } dbus_state_e;

  // Byte lanes are big-endian: byte0 lives in bits 31:24 and is selected by 8.
  localparam logic [3:0] DSEL_FSL  = 4'h0;  // no memory cycle (FSL access)
  localparam logic [3:0] DSEL_B3   = 4'h1;  // bits  7:0
  localparam logic [3:0] DSEL_B2   = 4'h2;  // bits 15:8
  localparam logic [3:0] DSEL_B1   = 4'h4;  // bits 23:16
  localparam logic [3:0] DSEL_B0   = 4'h8;  // bits 31:24
  localparam logic [3:0] DSEL_HLO  = 4'h3;  // bits 15:0
  localparam logic [3:0] DSEL_HHI  = 4'hC;  // bits 31:16
  localparam logic [3:0] DSEL_WORD = 4'hF;  // bits 31:0

  localparam logic [31:0] DEAD_DEAD = 32'hDEAD_DEAD;

endpackage

// File: rtl/aexm_lane_steer.sv
// -----------------------------------------------------------------------------
// aexm_lane_steer
//  Purely combinational byte-lane logic for the data bus.
//  Ports:
//   sel    in   4   byte-lane select (big-endian, see aexm_pkg)
//   rdat   in  32   raw memory read word
//   wdat   in  32   right-aligned store data
//   rsteer out 32   selected lanes right-aligned, zero-extended
//   wrep   out 32   store data replicated onto every lane of its size
//   legal  out  1   sel is one of 0,1,2,4,8,3,C,F
// -----------------------------------------------------------------------------
module aexm_lane_steer
  import aexm_pkg::*;
(
  input  logic [3:0]  sel,
  input  logic [31:0] rdat,
  input  logic [31:0] wdat,
  output logic [31:0] rsteer,
  output logic [31:0] wrep,
  output logic        legal
);

  // NOTE: every output gets a value before the case so no path leaves one
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    rsteer = '0;
    wrep   = wdat;
    legal  = 1'b1;
    case (sel)
      DSEL_B0:   begin rsteer = {24'h0, rdat[31:24]}; wrep = {4{wdat[7:0]}};  end
      DSEL_B1:   begin rsteer = {24'h0, rdat[23:16]}; wrep = {4{wdat[7:0]}};  end
      DSEL_B2:   begin rsteer = {24'h0, rdat[15:8]};  wrep = {4{wdat[7:0]}};  end
      DSEL_B3:   begin rsteer = {24'h0, rdat[7:0]};   wrep = {4{wdat[7:0]}};  end
      DSEL_HHI:  begin rsteer = {16'h0, rdat[31:16]}; wrep = {2{wdat[15:0]}}; end
      DSEL_HLO:  begin rsteer = {16'h0, rdat[15:0]};  wrep = {2{wdat[15:0]}}; end
      DSEL_WORD: rsteer = rdat;
      DSEL_FSL:  ;
      default:   legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/aexm_dbus_resp.sv
// -----------------------------------------------------------------------------
// aexm_dbus_resp
//  Data-side bus responder between aexm_xecu and the data cache / on-chip RAM.
//  Runs one access per dstb against a word-wide memory port that may insert
//  wait states, returns steered load data with a one-cycle dack, and aborts
//  with derr if mem_rdy does not arrive within TMO MEM cycles.
//  Ports:
//   gclk, grst_n            clock, asynchronous active-low reset
//   pre_addr[AW]            word address, valid the cycle before dstb
//   dstb, dsel, dwe, dwdat  access request from the execute stage
//   drdat, dack, derr       load data / completion pulse / error flag
//   dbusy                   high while a memory cycle is in flight
//   mem_addr, mem_stb, mem_we, mem_be, mem_wdat   memory request side
//   mem_rdat, mem_rdy                             memory response side
// -----------------------------------------------------------------------------
module aexm_dbus_resp
  import aexm_pkg::*;
#(
  parameter int AW  = 30,
  parameter int TMO = 15
) (
  input  logic          gclk,
  input  logic          grst_n,
  input  logic [AW-1:0] pre_addr,
  input  logic          dstb,
  input  logic [3:0]    dsel,
  input  logic          dwe,
  input  logic [31:0]   dwdat,
  output logic [31:0]   drdat,
  output logic          dack,
  output logic          derr,
  output logic          dbusy,
  output logic [AW-1:0] mem_addr,
  output logic          mem_stb,
  output logic          mem_we,
  output logic [3:0]    mem_be,
  output logic [31:0]   mem_wdat,
  input  logic [31:0]   mem_rdat,
  input  logic          mem_rdy
);

  localparam logic [7:0] TMO_W = 8'(TMO);

  dbus_state_e   state_q, state_d;
  logic [AW-1:0] addr_q;
  logic [7:0]    cnt_q;
  logic [7:0]    cnt_inc;
  logic [3:0]    steer_sel;
  logic [31:0]   rd_steer;
  logic [31:0]   wr_rep;
  logic          sel_legal;
  logic          access_ok;
  logic          timeout;

  // In IDLE the lanes come from the request; during MEM the request has gone
  // away, so the latched byte enables steer the returning read word.
  assign steer_sel = (state_q == IDLE) ? dsel : mem_be;
  assign access_ok = sel_legal && (dsel != DSEL_FSL);
  // The counter holds completed wait cycles; this MEM cycle is number cnt_q+1.
  assign cnt_inc   = cnt_q + 8'd1;
  assign timeout   = (cnt_inc == TMO_W);

  aexm_lane_steer u_lane_steer (
    .sel    (steer_sel),
    .rdat   (mem_rdat),
    .wdat   (dwdat),
    .rsteer (rd_steer),
    .wrep   (wr_rep),
    .legal  (sel_legal)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (dstb) state_d = access_ok ? MEM : DONE;
      MEM:     if (mem_rdy || timeout) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      addr_q   <= '0;
      cnt_q    <= '0;
      drdat    <= '0;
      dack     <= 1'b0;
      derr     <= 1'b0;
      dbusy    <= 1'b0;
      mem_addr <= '0;
      mem_stb  <= 1'b0;
      mem_we   <= 1'b0;
      mem_be   <= '0;
      mem_wdat <= '0;
    end else begin
      dack <= 1'b0;
      case (state_q)
        IDLE: begin
          addr_q <= pre_addr;
          if (dstb) begin
            if (access_ok) begin
              mem_stb  <= 1'b1;
              mem_addr <= addr_q;
              mem_be   <= dsel;
              mem_we   <= dwe;
              mem_wdat <= wr_rep;
              dbusy    <= 1'b1;
              cnt_q    <= '0;
            end else begin
              // FSL or illegal select: complete at once without a memory cycle.
              dack  <= 1'b1;
              derr  <= ~sel_legal;
              drdat <= '0;
            end
          end
        end
        MEM: begin
          // mem_rdy takes priority over a timeout landing in the same cycle.
          if (mem_rdy) begin
            mem_stb <= 1'b0;
            dbusy   <= 1'b0;
            dack    <= 1'b1;
            derr    <= 1'b0;
            drdat   <= mem_we ? '0 : rd_steer;
          end else if (timeout) begin
            mem_stb <= 1'b0;
            dbusy   <= 1'b0;
            dack    <= 1'b1;
            derr    <= 1'b1;
            drdat   <= DEAD_DEAD;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aexm_dbus_resp.sv
// -----------------------------------------------------------------------------
// tb_aexm_dbus_resp
//  Directed bench for aexm_dbus_resp. The driver describes each access as a
//  transaction (lanes, direction, wait count); a timeline model derives from
//  it which cycles must show mem_stb/dbusy, the single dack cycle and the
//  values drdat/derr must hold afterwards. One negedge process compares the
//  DUT against that timeline every cycle; literal checks pin the model.
// -----------------------------------------------------------------------------
module tb_aexm_dbus_resp;

  localparam int AW  = 30;
  localparam int TMO = 15;

  logic          gclk;
  logic          grst_n;
  logic [AW-1:0] pre_addr;
  logic          dstb;
  logic [3:0]    dsel;
  logic          dwe;
  logic [31:0]   dwdat;
  logic [31:0]   drdat;
  logic          dack;
  logic          derr;
  logic          dbusy;
  logic [AW-1:0] mem_addr;
  logic          mem_stb;
  logic          mem_we;
  logic [3:0]    mem_be;
  logic [31:0]   mem_wdat;
  logic [31:0]   mem_rdat;
  logic          mem_rdy;

  aexm_dbus_resp #(.AW(AW), .TMO(TMO)) dut (
    .gclk     (gclk),
    .grst_n   (grst_n),
    .pre_addr (pre_addr),
    .dstb     (dstb),
    .dsel     (dsel),
    .dwe      (dwe),
    .dwdat    (dwdat),
    .drdat    (drdat),
    .dack     (dack),
    .derr     (derr),
    .dbusy    (dbusy),
    .mem_addr (mem_addr),
    .mem_stb  (mem_stb),
    .mem_we   (mem_we),
    .mem_be   (mem_be),
    .mem_wdat (mem_wdat),
    .mem_rdat (mem_rdat),
    .mem_rdy  (mem_rdy)
  );

  initial gclk = 1'b0;
  always #5 gclk = ~gclk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction model ----------------
  int          cyc       = 0;
  bit          m_active  = 1'b0;
  int          m_issue   = 0;
  int          m_nmem    = 0;
  bit          m_hasmem  = 1'b0;
  logic [29:0] m_addr    = '0;
  logic [3:0]  m_be      = '0;
  logic        m_we      = 1'b0;
  logic [31:0] m_wdat    = '0;
  logic [31:0] m_drdat   = '0;
  logic        m_derr    = 1'b0;

  // Written only by the compare process.
  logic [31:0] h_drdat      = '0;
  logic        h_derr       = 1'b0;
  int          busy_total   = 0;
  int          ack_total    = 0;
  int          last_ack_cyc = 0;

  always @(posedge gclk) cyc <= cyc + 1;

  // Lanes selected by sel, right-aligned: bit j of sel owns byte bits 8j+7:8j.
  function automatic logic [31:0] load_val(input logic [3:0] sel, input logic [31:0] rd);
    int lo;
    int n;
    logic [31:0] mask;
    lo = 0;
    n  = 0;
    for (int j = 3; j >= 0; j--) begin
      if (sel[j]) begin
        lo = j;
        n++;
      end
    end
    mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
    return (rd >> (8 * lo)) & mask;
  endfunction

  function automatic logic [31:0] replicate(input logic [3:0] sel, input logic [31:0] wd);
    int n;
    n = 0;
    for (int j = 0; j < 4; j++) if (sel[j]) n++;
    if (n == 1) return 32'(wd[7:0]) * 32'h0101_0101;
    if (n == 2) return 32'(wd[15:0]) * 32'h0001_0001;
    return wd;
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge gclk) begin
    bit in_mem;
    bit ack_now;
    in_mem  = grst_n && m_active && m_hasmem && (cyc > m_issue) && (cyc <= m_issue + m_nmem);
    ack_now = grst_n && m_active && (cyc == m_issue + m_nmem + 1);
    if (!grst_n) begin
      h_drdat = '0;
      h_derr  = 1'b0;
    end else if (ack_now) begin
      h_drdat = m_drdat;
      h_derr  = m_derr;
    end
    if (dbusy === 1'b1) busy_total++;
    if (dack === 1'b1) begin
      ack_total++;
      last_ack_cyc = cyc;
    end
    check("mem_stb", mem_stb, in_mem);
    check("dbusy", dbusy, in_mem);
    check("dack", dack, ack_now);
    check("drdat", drdat, h_drdat);
    check("derr", derr, h_derr);
    if (in_mem) begin
      check("mem_addr", mem_addr, m_addr);
      check("mem_be", mem_be, m_be);
      check("mem_we", mem_we, m_we);
      check("mem_wdat", mem_wdat, m_wdat);
    end
  end

  // ---------------- driver ----------------
  // waits < 0 means mem_rdy is never raised.
  task automatic access(input logic [3:0] sel, input logic we, input logic [29:0] addr,
                        input logic [31:0] wd, input logic [31:0] rd, input int waits);
    bit legal;
    bit hasmem;
    int rdy_at;
    int n;
    legal  = sel inside {4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};
    hasmem = legal && (sel != 4'h0);
    rdy_at = (hasmem && waits >= 0 && waits < TMO) ? waits + 1 : 0;
    n      = !hasmem ? 0 : ((rdy_at != 0) ? rdy_at : TMO);
    pre_addr = addr;
    @(posedge gclk); #1;
    m_issue  = cyc;
    m_nmem   = n;
    m_hasmem = hasmem;
    m_addr   = addr;
    m_be     = sel;
    m_we     = we;
    m_wdat   = replicate(sel, wd);
    if (!legal)           begin m_drdat = '0;                 m_derr = 1'b1; end
    else if (!hasmem)     begin m_drdat = '0;                 m_derr = 1'b0; end
    else if (rdy_at == 0) begin m_drdat = 32'hDEAD_DEAD;      m_derr = 1'b1; end
    else if (we)          begin m_drdat = '0;                 m_derr = 1'b0; end
    else                  begin m_drdat = load_val(sel, rd);  m_derr = 1'b0; end
    m_active = 1'b1;
    dstb     = 1'b1;
    dsel     = sel;
    dwe      = we;
    dwdat    = wd;
    pre_addr = ~addr;  // must not leak into mem_addr
    for (int i = 1; i <= n; i++) begin
      @(posedge gclk); #1;
      dstb     = 1'b0;
      dsel     = 4'h0;
      dwe      = 1'b0;
      dwdat    = '0;
      mem_rdy  = (i == rdy_at);
      mem_rdat = (i == rdy_at) ? rd : 32'h5A5A_5A5A;
    end
    @(posedge gclk); #1;  // dack cycle
    dstb     = 1'b0;
    dsel     = 4'h0;
    dwe      = 1'b0;
    dwdat    = '0;
    mem_rdy  = 1'b0;
    mem_rdat = '0;
    @(posedge gclk); #1;  // back in IDLE
  endtask

  initial begin
    int b0;
    int a0;
    grst_n   = 1'b0;
    pre_addr = '0;
    dstb     = 1'b0;
    dsel     = 4'h0;
    dwe      = 1'b0;
    dwdat    = '0;
    mem_rdat = '0;
    mem_rdy  = 1'b0;
    repeat (3) @(posedge gclk);
    #1;
    check("rst_drdat", drdat, 32'h0);
    check("rst_dack", dack, 1'b0);
    check("rst_dbusy", dbusy, 1'b0);
    check("rst_mem_stb", mem_stb, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    grst_n = 1'b1;
    repeat (2) @(posedge gclk);
    #1;

    // 1: byte load, ready in the first MEM cycle
    access(4'h4, 1'b0, 30'h100, 32'h0, 32'h1122_3344, 0);
    check("t1_drdat", drdat, 32'h0000_0022);
    check("t1_derr", derr, 1'b0);
    check("t1_latency", last_ack_cyc - m_issue, 2);

    // 2: half store, three wait states
    b0 = busy_total;
    access(4'h3, 1'b1, 30'h040, 32'h0000_ABCD, 32'h0, 3);
    check("t2_busy_cycles", busy_total - b0, 4);
    check("t2_mem_wdat", mem_wdat, 32'hABCD_ABCD);
    check("t2_mem_be", mem_be, 4'h3);
    check("t2_mem_we", mem_we, 1'b1);
    check("t2_drdat", drdat, 32'h0);

    // 3: word load that never gets mem_rdy
    b0 = busy_total;
    access(4'hF, 1'b0, 30'h3FF, 32'h0, 32'h0, -1);
    check("t3_stb_cycles", busy_total - b0, 15);
    check("t3_derr", derr, 1'b1);
    check("t3_drdat", drdat, 32'hDEAD_DEAD);

    // 4: FSL then illegal select, neither touches memory
    b0 = busy_total;
    access(4'h0, 1'b0, 30'h010, 32'h0, 32'h0, 0);
    check("t4_fsl_derr", derr, 1'b0);
    check("t4_fsl_drdat", drdat, 32'h0);
    access(4'h5, 1'b0, 30'h011, 32'h0, 32'h0, 0);
    check("t4_ill_derr", derr, 1'b1);
    check("t4_no_mem", busy_total - b0, 0);

    // Remaining lane patterns
    access(4'h8, 1'b0, 30'h020, 32'h0, 32'h1122_3344, 1);
    check("lane8", drdat, 32'h0000_0011);
    access(4'h1, 1'b0, 30'h021, 32'h0, 32'h1122_3344, 0);
    check("lane1", drdat, 32'h0000_0044);
    access(4'h2, 1'b0, 30'h022, 32'h0, 32'h1122_3344, 2);
    check("lane2", drdat, 32'h0000_0033);
    access(4'hC, 1'b0, 30'h023, 32'h0, 32'h1122_3344, 0);
    check("laneC", drdat, 32'h0000_1122);
    access(4'h8, 1'b1, 30'h024, 32'h0000_005A, 32'h0, 0);
    check("byte_store_wdat", mem_wdat, 32'h5A5A_5A5A);
    access(4'hF, 1'b1, 30'h025, 32'h1234_5678, 32'h0, 1);
    check("word_store_wdat", mem_wdat, 32'h1234_5678);

    // 5: reset while in MEM
    pre_addr = 30'h055;
    @(posedge gclk); #1;
    m_issue  = cyc;
    m_nmem   = TMO;
    m_hasmem = 1'b1;
    m_addr   = 30'h055;
    m_be     = 4'hF;
    m_we     = 1'b0;
    m_wdat   = '0;
    m_drdat  = 32'hDEAD_DEAD;
    m_derr   = 1'b1;
    m_active = 1'b1;
    dstb     = 1'b1;
    dsel     = 4'hF;
    dwe      = 1'b0;
    dwdat    = '0;
    pre_addr = '0;
    @(posedge gclk); #1;
    dstb = 1'b0;
    dsel = 4'h0;
    @(posedge gclk); #1;
    check("t5_stb_before", mem_stb, 1'b1);
    #1;
    grst_n   = 1'b0;
    m_active = 1'b0;
    #1;
    check("t5_stb_async", mem_stb, 1'b0);
    check("t5_busy_async", dbusy, 1'b0);
    @(posedge gclk); #1;
    grst_n = 1'b1;
    a0 = ack_total;
    repeat (20) @(posedge gclk);
    #1;
    check("t5_no_ack", ack_total - a0, 0);
    access(4'h8, 1'b0, 30'h200, 32'h0, 32'hCAFE_BABE, 0);
    check("t5_after_drdat", drdat, 32'h0000_00CA);
    check("t5_after_derr", derr, 1'b0);

    // 6: mem_rdy in the same cycle the wait limit is reached
    b0 = busy_total;
    access(4'hF, 1'b0, 30'h2AA, 32'h0, 32'h89AB_CDEF, TMO - 1);
    check("t6_derr", derr, 1'b0);
    check("t6_drdat", drdat, 32'h89AB_CDEF);
    check("t6_stb_cycles", busy_total - b0, 15);

    repeat (2) @(posedge gclk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
